// File: rtl/regfile_pkg.sv
// Shared constants for the parametrised register file: reset-content modes
// and the default geometry used when no overrides are given.
package regfile_pkg;

    localparam int INIT_ZERO  = 0;
    localparam int INIT_INDEX = 1;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 4;
    localparam int DEF_NREGS  = 15;
    localparam int DEF_NRD    = 2;
    localparam int DEF_NWR    = 2;

endpackage

// File: rtl/regfile_sb_if.sv
// ID/WB-facing bus of the register file: read ports, write ports, issue marking
// and the scoreboard view. The pipeline drives it as master, the register file is slave.
interface regfile_sb_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NREGS  = DEF_NREGS,
    parameter int NRD    = DEF_NRD,
    parameter int NWR    = DEF_NWR
);
    logic [NRD*ADDR_W-1:0] rd_addr;
    logic [NRD*DATA_W-1:0] rd_data;
    logic [NRD-1:0]        rd_busy;
    logic [NWR-1:0]        wr_en;
    logic [NWR*ADDR_W-1:0] wr_addr;
    logic [NWR*DATA_W-1:0] wr_data;
    logic                  iss_en;
    logic [ADDR_W-1:0]     iss_addr;
    logic                  flush;
    logic [NREGS-1:0]      pend;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
        input  rd_data, rd_busy, pend
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, flush,
        output rd_data, rd_busy, pend
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on writeback,
// wiped on flush; also reports per-read-port hazards not already covered by bypass.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NREGS  = DEF_NREGS,
    parameter int NRD    = DEF_NRD,
    parameter int NWR    = DEF_NWR
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NWR-1:0]        wr_en,
    input  logic [NWR*ADDR_W-1:0] wr_addr,
    input  logic                  iss_en,
    input  logic [ADDR_W-1:0]     iss_addr,
    input  logic                  flush,
    input  logic [NRD*ADDR_W-1:0] rd_addr,
    output logic [NREGS-1:0]      pend,
    output logic [NRD-1:0]        rd_busy
);
    logic [NREGS-1:0] pend_q;
    logic [NREGS-1:0] pend_d;

    // Issue is applied after the clears so the newer instruction keeps ownership.
    always_comb begin
        pend_d = pend_q;
        if (flush) begin
            pend_d = '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                for (int p = 0; p < NWR; p++) begin
                    if (wr_en[p] && 32'(wr_addr[p*ADDR_W +: ADDR_W]) == i) begin
                        pend_d[i] = 1'b0;
                    end
                end
                if (iss_en && 32'(iss_addr) == i) begin
                    pend_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    assign pend = pend_q;

    for (genvar k = 0; k < NRD; k++) begin : g_busy
        logic [ADDR_W-1:0] ra;
        logic              busy;

        assign ra = rd_addr[k*ADDR_W +: ADDR_W];

        always_comb begin
            busy = 1'b0;
            for (int i = 0; i < NREGS; i++) begin
                if (32'(ra) == i) begin
                    busy = pend_q[i];
                end
            end
            for (int p = 0; p < NWR; p++) begin
                if (wr_en[p] && wr_addr[p*ADDR_W +: ADDR_W] == ra) begin
                    busy = 1'b0;
                end
            end
        end

        assign rd_busy[k] = busy;
    end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with same-cycle write-through bypass and a pending-write
// scoreboard for ID-stage hazard detection. Addresses at or above NREGS are inert.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int NREGS     = DEF_NREGS,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int NRD       = DEF_NRD,
    parameter int NWR       = DEF_NWR,
    parameter int INIT_MODE = INIT_INDEX
) (
    input  logic        clk,
    input  logic        rst,
    regfile_sb_if.slave bus
);
    logic [ADDR_W-1:0]       wa [NWR];
    logic [DATA_W-1:0]       wd [NWR];
    logic [NREGS*DATA_W-1:0] regs_flat;

    for (genvar p = 0; p < NWR; p++) begin : g_wport
        assign wa[p] = bus.wr_addr[p*ADDR_W +: ADDR_W];
        assign wd[p] = bus.wr_data[p*DATA_W +: DATA_W];
    end

    // Each register picks the highest-numbered port addressing it.
    for (genvar i = 0; i < NREGS; i++) begin : g_reg
        logic              wsel;
        logic [DATA_W-1:0] wval;
        logic [DATA_W-1:0] q;

        always_comb begin
            wsel = 1'b0;
            wval = '0;
            for (int p = 0; p < NWR; p++) begin
                if (bus.wr_en[p] && 32'(wa[p]) == i) begin
                    wsel = 1'b1;
                    wval = wd[p];
                end
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                q <= (INIT_MODE == INIT_INDEX) ? DATA_W'(i) : '0;
            end else if (wsel) begin
                q <= wval;
            end
        end

        assign regs_flat[i*DATA_W +: DATA_W] = q;
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rport
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd;

        assign ra = bus.rd_addr[k*ADDR_W +: ADDR_W];

        always_comb begin
            rd = '0;
            for (int i = 0; i < NREGS; i++) begin
                if (32'(ra) == i) begin
                    rd = regs_flat[i*DATA_W +: DATA_W];
                end
            end
            for (int p = 0; p < NWR; p++) begin
                if (bus.wr_en[p] && wa[p] == ra && 32'(ra) < NREGS) begin
                    rd = wd[p];
                end
            end
        end

        assign bus.rd_data[k*DATA_W +: DATA_W] = rd;
    end

    regfile_scoreboard #(
        .ADDR_W (ADDR_W),
        .NREGS  (NREGS),
        .NRD    (NRD),
        .NWR    (NWR)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (bus.wr_en),
        .wr_addr  (bus.wr_addr),
        .iss_en   (bus.iss_en),
        .iss_addr (bus.iss_addr),
        .flush    (bus.flush),
        .rd_addr  (bus.rd_addr),
        .pend     (bus.pend),
        .rd_busy  (bus.rd_busy)
    );

endmodule

// File: tb/tb_regfile_sb.sv
// Randomised scoreboard bench for regfile_sb: stimulus pushes expected outputs from a
// behavioural model into a queue, a negedge monitor pops and compares.
module tb_regfile_sb;
    import regfile_pkg::*;

    localparam int NR = 15;

    typedef struct {
        logic [1:0][31:0] rd_data;
        logic [1:0]       busy;
        logic [NR-1:0]    pend;
        string            tag;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    regfile_sb_if bus_if ();

    regfile_sb #(
        .DATA_W    (32),
        .NREGS     (NR),
        .ADDR_W    (4),
        .NRD       (2),
        .NWR       (2),
        .INIT_MODE (INIT_INDEX)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    exp_t        exp_q [$];
    int          n_checks = 0;
    int          n_fail   = 0;

    logic [31:0] mem [NR];
    logic [NR-1:0] pendm;

    logic [3:0]  ra_m [2];
    logic [3:0]  wa_m [2];
    logic [31:0] wd_m [2];
    logic [1:0]  we_m;
    logic        iss_m;
    logic [3:0]  ia_m;
    logic        fl_m;

    task automatic model_reset();
        for (int i = 0; i < NR; i++) mem[i] = 32'(i);
        pendm = '0;
    endtask

    task automatic drive_bus();
        bus_if.rd_addr  = {ra_m[1], ra_m[0]};
        bus_if.wr_en    = we_m;
        bus_if.wr_addr  = {wa_m[1], wa_m[0]};
        bus_if.wr_data  = {wd_m[1], wd_m[0]};
        bus_if.iss_en   = iss_m;
        bus_if.iss_addr = ia_m;
        bus_if.flush    = fl_m;
    endtask

    // Expected combinational view: stored value, overridden by the newest same-cycle write.
    task automatic push_expected(input string tag);
        exp_t e;
        e.tag  = tag;
        e.pend = pendm;
        for (int k = 0; k < 2; k++) begin
            e.rd_data[k] = 32'h0;
            e.busy[k]    = 1'b0;
            if (ra_m[k] < 4'(NR)) begin
                e.rd_data[k] = mem[ra_m[k]];
                e.busy[k]    = pendm[ra_m[k]];
                for (int p = 0; p < 2; p++) begin
                    if (we_m[p] && wa_m[p] == ra_m[k]) begin
                        e.rd_data[k] = wd_m[p];
                        e.busy[k]    = 1'b0;
                    end
                end
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic model_step();
        for (int p = 0; p < 2; p++) begin
            if (we_m[p] && wa_m[p] < 4'(NR)) mem[wa_m[p]] = wd_m[p];
        end
        if (fl_m) begin
            pendm = '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (we_m[p] && wa_m[p] < 4'(NR)) pendm[wa_m[p]] = 1'b0;
            end
            if (iss_m && ia_m < 4'(NR)) pendm[ia_m] = 1'b1;
        end
    endtask

    task automatic applyStimulus(
        input logic [3:0]  ra0, input logic [3:0] ra1,
        input logic [1:0]  we,
        input logic [3:0]  wa0, input logic [3:0] wa1,
        input logic [31:0] wd0, input logic [31:0] wd1,
        input logic        iss, input logic [3:0] ia,
        input logic        fl,  input string tag
    );
        @(posedge clk);
        #1;
        ra_m[0] = ra0; ra_m[1] = ra1;
        we_m    = we;
        wa_m[0] = wa0; wa_m[1] = wa1;
        wd_m[0] = wd0; wd_m[1] = wd1;
        iss_m   = iss; ia_m = ia; fl_m = fl;
        drive_bus();
        push_expected(tag);
        model_step();
    endtask

    task automatic idle_read(input logic [3:0] ra0, input logic [3:0] ra1, input string tag);
        applyStimulus(ra0, ra1, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 1'b0, 4'd0, 1'b0, tag);
    endtask

    task automatic checkOutput(input exp_t e);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (bus_if.rd_data[k*32 +: 32] !== e.rd_data[k]) begin
                n_fail++;
                $display("[TB] FAIL %s rd_data[%0d]: got %h expected %h",
                         e.tag, k, bus_if.rd_data[k*32 +: 32], e.rd_data[k]);
            end
        end
        n_checks++;
        if (bus_if.rd_busy !== e.busy) begin
            n_fail++;
            $display("[TB] FAIL %s rd_busy: got %b expected %b", e.tag, bus_if.rd_busy, e.busy);
        end
        n_checks++;
        if (bus_if.pend !== e.pend) begin
            n_fail++;
            $display("[TB] FAIL %s pend: got %b expected %b", e.tag, bus_if.pend, e.pend);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        ra_m[0] = 4'd3; ra_m[1] = 4'd14;
        wa_m[0] = 4'd0; wa_m[1] = 4'd0;
        wd_m[0] = 32'h0; wd_m[1] = 32'h0;
        we_m = 2'b00; iss_m = 1'b0; ia_m = 4'd0; fl_m = 1'b0;
        drive_bus();
        #1;
        rst = 1'b0;
        model_reset();
        push_expected("reset_state");
        @(negedge clk);
        #1;
        rst = 1'b1;

        applyStimulus(4'd5, 4'd0, 2'b11, 4'd5, 4'd5, 32'hDEAD_BEEF, 32'h0000_1234,
                      1'b0, 4'd0, 1'b0, "dual_write_bypass");
        idle_read(4'd5, 4'd4, "dual_write_stored");

        applyStimulus(4'd7, 4'd0, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 1'b1, 4'd7, 1'b0, "issue_r7");
        idle_read(4'd7, 4'd3, "r7_busy_1");
        idle_read(4'd3, 4'd7, "r7_busy_2");
        applyStimulus(4'd7, 4'd7, 2'b01, 4'd7, 4'd0, 32'h0000_0055, 32'h0, 1'b0, 4'd0, 1'b0, "r7_writeback");
        idle_read(4'd7, 4'd0, "r7_cleared");

        applyStimulus(4'd2, 4'd1, 2'b10, 4'd0, 4'd2, 32'h0, 32'hCAFE_0002, 1'b1, 4'd2, 1'b0, "issue_write_r2");
        idle_read(4'd2, 4'd1, "r2_still_pending");

        applyStimulus(4'd1, 4'd4, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 1'b1, 4'd1, 1'b0, "issue_r1");
        applyStimulus(4'd1, 4'd4, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 1'b1, 4'd4, 1'b0, "issue_r4");
        applyStimulus(4'd9, 4'd4, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 1'b1, 4'd9, 1'b0, "issue_r9");
        applyStimulus(4'd9, 4'd6, 2'b00, 4'd0, 4'd0, 32'h0, 32'h0, 1'b1, 4'd6, 1'b1, "flush_with_issue");
        idle_read(4'd9, 4'd6, "after_flush");

        applyStimulus(4'd15, 4'd5, 2'b11, 4'd15, 4'd15, 32'hFFFF_0001, 32'hFFFF_0002,
                      1'b1, 4'd15, 1'b0, "write_out_of_range");
        idle_read(4'd15, 4'd14, "out_of_range_read");

        for (int n = 0; n < 400; n++) begin
            logic [3:0] hi;
            hi = (n % 2 == 0) ? 4'd3 : 4'd15;
            applyStimulus(4'($urandom_range(0, 32'(hi))), 4'($urandom_range(0, 32'(hi))),
                          2'($urandom_range(0, 3)),
                          4'($urandom_range(0, 32'(hi))), 4'($urandom_range(0, 32'(hi))),
                          $urandom, $urandom,
                          1'($urandom_range(0, 2) == 0), 4'($urandom_range(0, 32'(hi))),
                          1'($urandom_range(0, 15) == 0), "random");
        end

        // Reset lands mid-cycle while a write is on the bus; the write must not survive.
        @(posedge clk);
        #1;
        ra_m[0] = 4'd9; ra_m[1] = 4'd12;
        we_m    = 2'b11;
        wa_m[0] = 4'd3; wa_m[1] = 4'd6;
        wd_m[0] = 32'hAAAA_5555; wd_m[1] = 32'h5555_AAAA;
        iss_m   = 1'b1; ia_m = 4'd8; fl_m = 1'b0;
        drive_bus();
        #2;
        rst = 1'b0;
        model_reset();
        push_expected("async_reset");
        @(posedge clk);
        #1;
        push_expected("reset_hold");
        @(negedge clk);
        #1;
        rst  = 1'b1;
        we_m = 2'b00; iss_m = 1'b0;
        drive_bus();

        idle_read(4'd3, 4'd6, "post_reset_values");
        applyStimulus(4'd8, 4'd0, 2'b01, 4'd0, 4'd0, 32'h0BAD_F00D, 32'h0, 1'b1, 4'd8, 1'b0, "first_edge_after_reset");
        idle_read(4'd0, 4'd8, "post_reset_update");

        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL drain: got %0d unchecked entries expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised successor to the core's single-write register file, with configurable width, depth and read/write port count. It adds same-cycle write-through bypass and a pending-write scoreboard that the ID stage uses for hazard detection. It sits between ID (reads, issue marking) and WB (writes). Register 15 (PC) stays outside the block.

## Interface
- DATA_W, 32, register width in bits
- NREGS, 15, number of architectural registers held; must be ≤ 2**ADDR_W
- ADDR_W, 4, register address width
- NRD, 2, number of read ports
- NWR, 2, number of write ports; a higher port index has higher priority
- INIT_MODE, 1, reset contents: 0 = all zero, 1 = register i holds value i
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset rst, asynchronous, active-low
- rd_addr  in  NRD*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NRD*DATA_W  read data, combinational
- rd_busy  out  NRD  read register has a write outstanding
- wr_en  in  NWR  per-port write enable
- wr_addr  in  NWR*ADDR_W  write addresses
- wr_data  in  NWR*DATA_W  write data
- iss_en  in  1  mark iss_addr as pending-write (instruction issued with WB_EN)
- iss_addr  in  ADDR_W  destination being issued
- flush  in  1  clear the whole scoreboard (branch taken)
- pend  out  NREGS  scoreboard bit vector, registered

## Operation
- Storage: NREGS × DATA_W registers, indices 0..NREGS-1.
- Reset (rst=0, asynchronous): every register takes its INIT_MODE value and pend goes to 0. Outputs follow combinationally from this state.
- Write: at the rising edge, for each port p with wr_en[p] set and wr_addr < NREGS, the register takes wr_data[p].
  - If several ports write the same address, the highest p wins.
  - A write to an address ≥ NREGS is ignored and has no side effects.
- Read: rd_data[k] returns the register at rd_addr[k]. If rd_addr[k] ≥ NREGS, it returns 0.
- Bypass: if any wr_en[p] is set with wr_addr[p] == rd_addr[k] < NREGS, rd_data[k] returns the same-cycle wr_data of the highest such p instead of the stored value.
- Scoreboard: one bit per register, updated at the rising edge in this priority order:
  - flush: all bits go to 0. A simultaneous iss_en is also dropped.
  - Otherwise, iss_en with iss_addr < NREGS sets that bit. This overrides a same-cycle clearing write to the same address, because the newer instruction owns the register.
  - Otherwise, any wr_en[p] to an address clears that bit.
  - Bits for other addresses are unaffected.
- rd_busy[k] = pend[rd_addr[k]] && no same-cycle write to rd_addr[k]. In other words, a write being committed this cycle resolves the hazard through bypass. rd_busy[k] is 0 for rd_addr ≥ NREGS.

## Timing
- Read and bypass paths are combinational, with 0-cycle latency.
- Register write and scoreboard updates become visible in stored state one rising edge later.
- pend is a direct register output; it is never combinationally affected by same-cycle inputs.
- rd_busy is combinational from rd_addr, pend and wr_*.
- Reset asserted mid-operation overrides any in-flight write or issue in that cycle.
- Reset release is synchronous-safe: the first edge after rst rises performs normal updates.

## Structure
- Shared package `regfile_pkg`:
  - INIT_ZERO / INIT_INDEX constants for INIT_MODE
  - default DATA_W, ADDR_W and NREGS localparams
- Natural sub-module `regfile_scoreboard`: holds the pend register and its set/clear/flush priority logic, and outputs pend plus the per-read-port busy terms.
- Storage, the write-priority mux and bypass stay in the top module as generate loops over NRD and NWR.

## Test plan
- Reset, INIT_MODE=1: read ports at addresses 3 and 14 → rd_data 3 and 14; pend = 0.
- Port 0 writes 0xDEAD_BEEF to r5 while port 1 writes 0x1234 to r5 in the same cycle → after the edge r5 = 0x1234; rd_addr=5 shows 0x1234 in the write cycle via bypass.
- iss_en r7 at edge t → pend[7]=1 and rd_busy=1 for r7. wr_en r7 with 0x55 at t+3 → rd_busy=0 in that cycle with rd_data=0x55, and pend[7]=0 after the edge.
- iss_en r2 and wr_en r2 in the same cycle → pend[2]=1 after the edge.
- Set pend for r1, r4 and r9; assert flush together with iss_en r6 → pend = 0.
- Write to address 15 with NREGS=15 → no register changes; rd_addr=15 returns 0 with rd_busy=0.
- Assert rst asynchronously mid-cycle during a write → all registers immediately hold their index values and pend = 0.
